// File: rtl/mcore_bitreader.sv
// mcore_bitreader: prefetches 32-bit words over mem_if and
// serialises them MSB-first into bpp-wide fields for the cel engine.
module mcore_bitreader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PREFETCH_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [4:0]              cfg_bpp,
  input  logic [4:0]              cfg_skip_bits,
  output logic                    busy,
  output logic                    err,
  output logic                    fld_valid,
  input  logic                    fld_ready,
  output logic [15:0]             fld_data,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  input  logic                    mem_rsp_error
);

  localparam int PW = $clog2(PREFETCH_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(PREFETCH_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         out_next;
  logic [CW-1:0]         fcnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [31:0]           fifo [PREFETCH_DEPTH];
  logic [47:0]           bbuf;
  logic [5:0]            bcnt;
  logic [4:0]            bpp;
  logic [4:0]            skip;

  logic        gnt_ok;
  logic        rsp_any;
  logic        rsp_err;
  logic        push;
  logic        pop;
  logic        hs;
  logic        flush;
  logic [CW:0] inflight;
  logic [47:0] sh_buf;
  logic [5:0]  sh_cnt;
  logic [31:0] word;
  logic [31:0] wsk;
  logic [47:0] app;
  logic [5:0]  nbits;
  logic        unused_addr;

  assign unused_addr = ^cfg_base_addr[1:0];

  assign busy      = (state != IDLE);
  assign mem_addr  = addr;
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;
  assign mem_be    = '1;

  assign inflight = {1'b0, outstanding} + {1'b0, fcnt};
  assign mem_req  = (state == RUN) && (inflight < DEPTH);
  assign gnt_ok   = mem_req && mem_gnt;
  assign rsp_any  = mem_rsp_valid && (state != IDLE);
  assign rsp_err  = (state == RUN) && mem_rsp_valid && mem_rsp_error;
  assign out_next = outstanding + CW'(gnt_ok) - CW'(rsp_any);

  assign fld_valid = (bcnt >= {1'b0, bpp});
  assign fld_data  = bbuf[47:32] >> (5'd16 - bpp);
  assign hs        = fld_valid && fld_ready;

  assign sh_buf = hs ? (bbuf << bpp) : bbuf;
  assign sh_cnt = hs ? (bcnt - {1'b0, bpp}) : bcnt;

  // Next word lands directly below the surviving bits; skip trims its MSBs.
  assign word  = fifo[rd_ptr];
  assign wsk   = word << skip;
  assign app   = {wsk, 16'h0} >> sh_cnt;
  assign nbits = 6'd32 - {1'b0, skip};

  assign push  = (state == RUN) && mem_rsp_valid && !mem_rsp_error;
  assign pop   = (state == RUN) && (fcnt != '0) && (sh_cnt <= 6'd16);
  assign flush = ((state == IDLE) && start) ||
                 ((state == RUN) && (stop || rsp_err));

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      outstanding <= '0;
      bpp         <= 5'd16;
      err         <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (gnt_ok) addr <= addr + ADDR_WIDTH'(4);
      unique case (state)
        IDLE: if (start) begin
          state <= RUN;
          addr  <= {cfg_base_addr[ADDR_WIDTH-1:2], 2'b00};
          bpp   <= (cfg_bpp == 5'd0 || cfg_bpp > 5'd16) ? 5'd16 : cfg_bpp;
          err   <= 1'b0;
        end
        RUN: if (stop || rsp_err) begin
          state <= DRAIN;
          if (rsp_err) err <= 1'b1;
        end
        DRAIN: if (out_next == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      fcnt   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      bbuf   <= '0;
      bcnt   <= '0;
      skip   <= '0;
    end else begin
      if (state == IDLE && start) skip <= cfg_skip_bits;
      else if (pop) skip <= '0;
      if (flush) begin
        fcnt   <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        bbuf   <= '0;
        bcnt   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fcnt <= fcnt + CW'(push) - CW'(pop);
        bbuf <= pop ? (sh_buf | app) : sh_buf;
        bcnt <= pop ? (sh_cnt + nbits) : sh_cnt;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo[wr_ptr] <= mem_rsp_rdata[31:0];
  end

  a_no_idle_rsp: assert property (
    @(posedge aclk) disable iff (rst) !(state == IDLE && mem_rsp_valid));

endmodule

// File: tb/tb_mcore_bitreader.sv
// tb_mcore_bitreader: directed streams through a latency/grant memory
// model; a negedge monitor pops expected fields from a scoreboard queue.
module tb_mcore_bitreader;

  logic        aclk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [4:0]  cfg_bpp = '0;
  logic [4:0]  cfg_skip_bits = '0;
  logic        busy;
  logic        err;
  logic        fld_valid;
  logic        fld_ready = 1'b0;
  logic [15:0] fld_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        mem_rsp_error = 1'b0;

  always #5 aclk = ~aclk;

  mcore_bitreader dut (
    .aclk(aclk), .rst(rst), .start(start), .stop(stop),
    .cfg_base_addr(cfg_base_addr), .cfg_bpp(cfg_bpp),
    .cfg_skip_bits(cfg_skip_bits), .busy(busy), .err(err),
    .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_data(fld_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_error(mem_rsp_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_rand = 0;
  int          gnt_left = -1;
  int          wait_cnt = 0;
  int          tb_out = 0;
  int          last_rsp_cyc = -1;
  logic [31:0] exp_addr = '0;
  logic [31:0] err_addr = 32'hFFFF_FFFC;

  // Memory model: drives gnt/rsp 1 time unit after each rising edge.
  always @(posedge aclk) begin
    #1;
    cyc = cyc + 1;
    if (rst) begin
      rq.delete();
      tb_out = 0;
      wait_cnt = 0;
      mem_gnt = 0;
      mem_rsp_valid = 0;
      mem_rsp_error = 0;
      mem_rsp_rdata = '0;
    end else begin
      mem_rsp_valid = 0;
      mem_rsp_error = 0;
      mem_rsp_rdata = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_rsp_valid = 1;
        mem_rsp_rdata = rq[0].d;
        mem_rsp_error = rq[0].e;
        void'(rq.pop_front());
        tb_out--;
        last_rsp_cyc = cyc;
      end
      mem_gnt = 0;
      if (mem_req && gnt_left != 0) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          mem_gnt = 1;
          check("mem_addr", mem_addr, exp_addr);
          exp_addr += 4;
          rq.push_back('{d: memw(mem_addr), e: (mem_addr == err_addr),
                         due: cyc + lat});
          tb_out++;
          check("outstanding_le_4", 64'(tb_out <= 4), 1);
          if (gnt_left > 0) gnt_left--;
          wait_cnt = gnt_rand ? int'($urandom_range(0, 3)) : 0;
        end
      end
    end
  end

  logic [15:0] exp_q[$];
  int          hs_cyc[$];
  int          first_valid_cyc = -1;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;

  always @(negedge aclk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", fld_valid, 1);
        check("stall_data", fld_data, prev_data);
      end
      if (fld_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (fld_valid && fld_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_field actual=0x%0h required=none", fld_data);
        end else begin
          check("field", fld_data, exp_q.pop_front());
          hs_cyc.push_back(cyc);
        end
      end
      prev_stall = fld_valid && !fld_ready && !stop &&
                   !(mem_rsp_valid && mem_rsp_error);
      prev_data = fld_data;
    end else begin
      prev_stall = 0;
    end
  end

  int start_cyc = 0;

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic start_stream(input logic [31:0] base,
                              input logic [4:0] bpp,
                              input logic [4:0] skip);
    cfg_base_addr = base;
    cfg_bpp = bpp;
    cfg_skip_bits = skip;
    exp_addr = base & 32'hFFFF_FFFC;
    start_cyc = cyc;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic finish_stream();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("fields_drained", exp_q.size(), 0);
    exp_q.delete();
    fld_ready = 0;
    stop = 1;
    tick();
    stop = 0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("busy_after_stop", busy, 0);
  endtask

  task automatic push_list(input logic [15:0] v[$]);
    foreach (v[i]) exp_q.push_back(v[i]);
  endtask

  initial begin
    int n;
    logic [31:0] w;
    logic [15:0] v;
    int p;

    #1 rst = 1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_fld_valid", fld_valid, 0);
    check("rst_fld_data", fld_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 0;
    repeat (2) tick();

    // nibbles of one word, latency and back-to-back delivery
    mem[32'h100] = 32'h12345678;
    lat = 1;
    fld_ready = 1;
    first_valid_cyc = -1;
    hs_cyc.delete();
    push_list('{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8});
    start_stream(32'h100, 5'd4, 5'd0);
    check("busy_after_start", busy, 1);
    finish_stream();
    check("first_valid_latency", first_valid_cyc, start_cyc + 3 + lat);
    if (hs_cyc.size() == 8)
      check("consecutive_fields", hs_cyc[7] - hs_cyc[0], 7);
    else
      check("consecutive_count", hs_cyc.size(), 8);

    // 6-bit fields spanning a word boundary
    mem[32'h600] = 32'hFFFF_FFFF;
    mem[32'h604] = 32'h0;
    mem[32'h608] = 32'h0;
    fld_ready = 1;
    push_list('{16'h3F, 16'h3F, 16'h3F, 16'h3F, 16'h3F,
                16'h30, 16'h00, 16'h00, 16'h00, 16'h00});
    start_stream(32'h600, 5'd6, 5'd0);
    finish_stream();

    // byte fields with skip
    mem[32'h200] = 32'hAABB_CCDD;
    mem[32'h204] = 32'h1122_3344;
    fld_ready = 1;
    push_list('{16'hBB, 16'hCC, 16'hDD, 16'h11});
    start_stream(32'h200, 5'd8, 5'd8);
    finish_stream();

    // bpp=0 means 16, skip=31, unaligned base
    mem[32'h700] = 32'h0000_0001;
    mem[32'h704] = 32'hABCD_1234;
    fld_ready = 1;
    push_list('{16'hD5E6, 16'h891A});
    start_stream(32'h703, 5'd0, 5'd31);
    finish_stream();

    // backpressure with random grant delay, golden bit model
    lat = 2;
    gnt_rand = 1;
    for (int i = 0; i < 40; i++) begin
      v = '0;
      for (int b = 0; b < 5; b++) begin
        p = 3 + i * 5 + b;
        w = memw(32'h500 + 32'(4 * (p / 32)));
        v = {v[14:0], w[31 - (p % 32)]};
      end
      exp_q.push_back(v);
    end
    fld_ready = 1;
    start_stream(32'h500, 5'd5, 5'd3);
    n = 0;
    while (exp_q.size() > 25 && n < 500) begin
      tick();
      n++;
    end
    check("bp_progress", 64'(exp_q.size() <= 25), 1);
    fld_ready = 0;
    repeat (10) tick();
    fld_ready = 1;
    finish_stream();
    gnt_rand = 0;

    // abort with two responses outstanding
    lat = 6;
    gnt_left = 2;
    fld_ready = 0;
    start_stream(32'h800, 5'd8, 5'd0);
    n = 0;
    while (tb_out != 2 && n < 20) begin
      tick();
      n++;
    end
    check("abort_outstanding", tb_out, 2);
    stop = 1;
    tick();
    stop = 0;
    check("abort_mem_req", mem_req, 0);
    check("abort_fld_valid", fld_valid, 0);
    check("abort_busy_drain", busy, 1);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("abort_busy_fell", busy, 0);
    check("abort_fall_timing", last_rsp_cyc, cyc - 1);
    check("abort_absorbed", tb_out, 0);
    gnt_left = -1;
    lat = 1;
    mem[32'h300] = 32'hC0FF_EE11;
    fld_ready = 1;
    push_list('{16'hC0, 16'hFF, 16'hEE, 16'h11});
    start_stream(32'h300, 5'd8, 5'd0);
    finish_stream();

    // response error on the third word
    lat = 2;
    err_addr = 32'h908;
    fld_ready = 0;
    start_stream(32'h900, 5'd8, 5'd0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("err_busy_fell", busy, 0);
    check("err_set", err, 1);
    err_addr = 32'hFFFF_FFFC;
    start_stream(32'hA00, 5'd8, 5'd0);
    check("err_cleared_by_start", err, 0);
    finish_stream();

    // asynchronous reset mid-run
    fld_ready = 0;
    start_stream(32'hB00, 5'd4, 5'd0);
    repeat (6) tick();
    check("pre_rst_busy", busy, 1);
    #1 rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_fld_valid", fld_valid, 0);
    check("arst_fld_data", fld_data, 0);
    check("arst_mem_req", mem_req, 0);
    check("arst_mem_addr", mem_addr, 0);
    tick();
    tick();
    rst = 0;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_mem_req", mem_req, 0);
    check("post_rst_fld_valid", fld_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcore_bitreader.md
Name: mcore_bitreader

Overview:
- Upstream feeder for the cel draw engine in mcore_top.
- Fetches consecutive 32-bit source words from external memory over the mem_if request/grant/response protocol.
- Serialises the words MSB-first into fields of a programmable width (bits per pixel), one field per valid/ready beat.
- Prefetches ahead so the draw engine can consume at most one field per clock.

Parameters:
- DATA_WIDTH, 32, memory data width; only 32 supported.
- ADDR_WIDTH, 32, byte address width.
- PREFETCH_DEPTH, 4, maximum words outstanding plus buffered (power of 2, >=2).

Ports:
- aclk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; latches cfg and begins; ignored while busy
- stop  in  1  one-cycle pulse; aborts current stream
- cfg_base_addr  in  ADDR_WIDTH  byte address of first word; bits[1:0] ignored
- cfg_bpp  in  5  field width, 1..16; 0 is treated as 16
- cfg_skip_bits  in  5  bits discarded from MSB of first word, 0..31
- busy  out  1  high from the cycle after start until fully idle
- err  out  1  sticky rsp_error flag; cleared by next accepted start
- fld_valid  out  1  field available
- fld_ready  in  1  consumer accepts field
- fld_data  out  16  field, right-aligned, zero-extended
- mem_req  out  1  read request
- mem_addr  out  ADDR_WIDTH  word-aligned byte address
- mem_we  out  1  constant 0
- mem_wdata  out  DATA_WIDTH  constant 0
- mem_be  out  DATA_WIDTH/8  constant all-ones
- mem_gnt  in  1  request accepted this cycle
- mem_rsp_valid  in  1  read data valid; responses arrive in request order
- mem_rsp_rdata  in  DATA_WIDTH  read data
- mem_rsp_error  in  1  response error

Behaviour:
- Reset (async assert, sync release): all outputs 0. State IDLE. Counters and bit buffer cleared.
- States:
  - IDLE: start -> RUN. Latches cfg, fetch pointer = base & ~3, skip_pending = cfg_skip_bits, err cleared.
  - RUN: stop or a response with mem_rsp_error=1 (err<=1) -> DRAIN.
  - DRAIN: issues no new requests. Discards incoming responses. Clears fld_valid and the bit buffer. When outstanding==0 -> IDLE.
  - busy = (state != IDLE).
- Fetch:
  - mem_req asserted in RUN while (outstanding + buffered_words) < PREFETCH_DEPTH.
  - mem_req, once high, holds with stable mem_addr until mem_gnt. Exception: transition to DRAIN drops the request the next cycle.
  - On gnt, address += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding++.
  - On rsp_valid, outstanding--. The word enters the word FIFO.
  - Simultaneous gnt and rsp_valid leave outstanding unchanged.
- Bit buffer:
  - 48-bit MSB-aligned shift register plus a 6-bit count.
  - A FIFO word is appended when count <= 16.
  - On append of the first word, skip_pending MSBs are dropped, then skip_pending = 0.
- Output:
  - fld_valid = 1 when count >= bpp.
  - fld_data = top bpp bits of the buffer.
  - fld_data and fld_valid stay stable while fld_valid & !fld_ready.
  - On handshake, shift left by bpp and count -= bpp. An append may occur in the same cycle.
  - Fields spanning a word boundary concatenate the tail of word N with the head of word N+1.
  - Sustained throughput: one field/clock when bpp <= 16 and memory grants every cycle with latency <= PREFETCH_DEPTH-1.
- Latency: start to first fld_valid = 1 (req) + grant wait + memory latency + 2 cycles.
- Stream has no end. The consumer counts fields and pulses stop; busy falls after outstanding responses drain.
- start in the same cycle as stop while busy: stop wins, start ignored.
- rsp_valid while IDLE: ignored. An assertion flags it in simulation.

Test Plan:
- Mem[0x100]=0x12345678. base=0x100, bpp=4, skip=0, fld_ready=1 -> fields 1,2,3,4,5,6,7,8 on consecutive cycles after the first; mem_addr sequence 0x100, 0x104, ...
- bpp=6, words 0xFFFFFFFF,0x00000000 -> five fields 0x3F, then 0x30 (boundary-spanning), then 0x00...
- base=0x200 with 0xAABBCCDD, bpp=8, skip=8 -> 0xBB, 0xCC, 0xDD, then the first byte of the word at 0x204.
- Backpressure: fld_ready low for 10 cycles mid-stream, mem_gnt randomly delayed 0-3 cycles, memory latency 2 -> fld_data stable while stalled; at most PREFETCH_DEPTH=4 words outstanding+buffered; no field lost or duplicated versus the golden model.
- Abort: stop with 2 responses outstanding -> mem_req low next cycle, fld_valid low, both responses absorbed, busy falls exactly after the last rsp_valid; a subsequent start at 0x300 streams correctly.
- Error and reset: rsp_error on the 3rd word -> err=1, DRAIN, busy falls. Separately, assert rst mid-RUN -> all outputs 0 immediately (asynchronous), and the block is idle after release.
